// File: rtl/pe_clk_gate_ctrl_if.sv
// Activity, wake and status signals between a PE's upstream logic and its clock-gate controller.
// The master drives PE activity and config; the slave (controller) returns gate enable and status.
interface pe_clk_gate_ctrl_if #(
  parameter int STAT_W = 16
);
  logic              pe_busy;
  logic              wake_req;
  logic              gate_allow;
  logic              clk_en;
  logic              pe_ready;
  logic              gated;
  logic [STAT_W-1:0] gated_cycles;

  modport master (
    output pe_busy, wake_req, gate_allow,
    input  clk_en, pe_ready, gated, gated_cycles
  );

  modport slave (
    input  pe_busy, wake_req, gate_allow,
    output clk_en, pe_ready, gated, gated_cycles
  );
endinterface

// File: rtl/pe_clk_gate_ctrl.sv
// Clock-gate enable controller for one PE: gates after a run of idle cycles, restores on wake
// and holds pe_ready low for a settle window. Runs on the free-running clock.
module pe_clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8,
  parameter int STAT_W      = 16
) (
  input logic               clk,
  input logic               reset,
  pe_clk_gate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_IDLE_CNT = 2'd1,
    ST_GATED    = 2'd2,
    ST_WAKE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LAST = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : CNT_W'(0);

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_idle_cnt, w_idle_cnt_next;
  logic [CNT_W-1:0]  r_wake_cnt, w_wake_cnt_next;
  logic [STAT_W-1:0] r_gated_cycles, w_gated_cycles_next;
  logic              r_clk_en, r_pe_ready, r_gated;
  logic              w_clk_en_next, w_pe_ready_next, w_gated_next;
  logic              w_idle;

  assign w_idle = !bus.pe_busy && !bus.wake_req && bus.gate_allow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_ACTIVE;
      r_idle_cnt     <= '0;
      r_wake_cnt     <= '0;
      r_gated_cycles <= '0;
      r_clk_en       <= 1'b1;
      r_pe_ready     <= 1'b1;
      r_gated        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_idle_cnt     <= w_idle_cnt_next;
      r_wake_cnt     <= w_wake_cnt_next;
      r_gated_cycles <= w_gated_cycles_next;
      r_clk_en       <= w_clk_en_next;
      r_pe_ready     <= w_pe_ready_next;
      r_gated        <= w_gated_next;
    end
  end

  // Any non-idle condition (including a wake on the terminal idle cycle) keeps the clock on.
  always_comb begin
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    w_wake_cnt_next = r_wake_cnt;
    case (r_state)
      ST_ACTIVE: begin
        w_idle_cnt_next = '0;
        if (w_idle) begin
          if (IDLE_CYCLES == 1) begin
            w_state_next = ST_GATED;
          end else begin
            w_state_next    = ST_IDLE_CNT;
            w_idle_cnt_next = CNT_W'(1);
          end
        end
      end
      ST_IDLE_CNT: begin
        if (!w_idle) begin
          w_state_next    = ST_ACTIVE;
          w_idle_cnt_next = '0;
        end else if (r_idle_cnt == IDLE_LAST) begin
          w_state_next    = ST_GATED;
          w_idle_cnt_next = '0;
        end else begin
          w_idle_cnt_next = r_idle_cnt + CNT_W'(1);
        end
      end
      ST_GATED: begin
        if (!w_idle) begin
          w_wake_cnt_next = '0;
          w_state_next    = (WAKE_CYCLES == 0) ? ST_ACTIVE : ST_WAKE;
        end
      end
      ST_WAKE: begin
        w_wake_cnt_next = r_wake_cnt + CNT_W'(1);
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_next    = ST_ACTIVE;
          w_wake_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = ST_ACTIVE;
        w_idle_cnt_next = '0;
        w_wake_cnt_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    w_clk_en_next       = (w_state_next != ST_GATED);
    w_pe_ready_next     = (w_state_next == ST_ACTIVE) || (w_state_next == ST_IDLE_CNT);
    w_gated_next        = (w_state_next == ST_GATED);
    w_gated_cycles_next = r_gated_cycles;
    if (r_state == ST_GATED && r_gated_cycles != {STAT_W{1'b1}}) begin
      w_gated_cycles_next = r_gated_cycles + STAT_W'(1);
    end
  end

  assign bus.clk_en       = r_clk_en;
  assign bus.pe_ready     = r_pe_ready;
  assign bus.gated        = r_gated;
  assign bus.gated_cycles = r_gated_cycles;

endmodule

// File: tb/tb_pe_clk_gate_ctrl.sv
// Self-checking bench: vector table with scoreboard for the default instance, plus hand
// sequences for async reset mid-sleep and counter saturation on a narrow-stat instance.
module tb_pe_clk_gate_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pe_clk_gate_ctrl_if #(.STAT_W(16)) bus_a ();
  pe_clk_gate_ctrl_if #(.STAT_W(4))  bus_b ();

  pe_clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(8), .STAT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  pe_clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0), .CNT_W(8), .STAT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  typedef struct {
    logic busy;
    logic wake;
    logic allow;
    logic en;
    logic rdy;
    logic gated;
    int   gc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   gc_model;
  logic prev_g;

  // gated_cycles grows by one for every cycle whose expected state was GATED.
  function automatic void add(input logic b, input logic w, input logic a,
                              input logic en, input logic rdy, input logic g);
    vec_t v;
    if (prev_g && gc_model < 65535) gc_model++;
    v.busy = b;  v.wake = w;  v.allow = a;
    v.en = en;   v.rdy = rdy; v.gated = g;
    v.gc = gc_model;
    vecs.push_back(v);
    prev_g = g;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t e;
    reset            = 1'b1;
    bus_a.pe_busy    = 1'b0;
    bus_a.wake_req   = 1'b0;
    bus_a.gate_allow = 1'b1;
    bus_b.pe_busy    = 1'b1;
    bus_b.wake_req   = 1'b0;
    bus_b.gate_allow = 1'b1;

    // Reset acts before any clock edge.
    #1;
    chk("rst_a_clk_en", int'(bus_a.clk_en), 1);
    chk("rst_a_pe_ready", int'(bus_a.pe_ready), 1);
    chk("rst_a_gated", int'(bus_a.gated), 0);
    chk("rst_a_gated_cycles", int'(bus_a.gated_cycles), 0);
    chk("rst_b_clk_en", int'(bus_b.clk_en), 1);
    @(negedge clk);
    reset = 1'b0;

    gc_model = 0;
    prev_g   = 1'b0;
    // Idle entry: gate after 17 edges, 3 gated cycles counted by cycle 20.
    for (int i = 1; i <= 20; i++) add(0, 0, 1, i < 17, i < 17, i >= 17);
    // One-cycle wake pulse; wake_req drops but the settle sequence completes.
    add(0, 1, 1, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0);
    // Busy pulse at idle cycle 10 restarts the count from 1.
    for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 1, 0);
    add(1, 0, 1, 1, 1, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1);
    // Wake via pe_busy.
    add(1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 0);
    add(1, 0, 1, 1, 1, 0);
    // wake_req on the terminal idle cycle wins.
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 1, 1, 0);
    add(0, 1, 1, 1, 1, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1);
    // gate_allow=0 wakes from GATED and holds the clock on.
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 100; i++) add(0, 0, 0, 1, 1, 0);
    // gate_allow falling in IDLE_CNT returns to ACTIVE.
    for (int i = 1; i <= 10; i++) add(0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 16; i++) add(0, 0, 1, 1, 1, 0);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      bus_a.pe_busy    = vecs[i].busy;
      bus_a.wake_req   = vecs[i].wake;
      bus_a.gate_allow = vecs[i].allow;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (bus_a.clk_en !== e.en || bus_a.pe_ready !== e.rdy || bus_a.gated !== e.gated ||
          int'(bus_a.gated_cycles) != e.gc) begin
        n_miss++;
        $display("FAIL vec%0d: got en=%b rdy=%b gated=%b gc=%0d, want en=%b rdy=%b gated=%b gc=%0d",
                 i, bus_a.clk_en, bus_a.pe_ready, bus_a.gated, bus_a.gated_cycles,
                 e.en, e.rdy, e.gated, e.gc);
      end else begin
        $display("ok   vec%0d b=%b w=%b a=%b -> en=%b rdy=%b gated=%b gc=%0d",
                 i, e.busy, e.wake, e.allow, e.en, e.rdy, e.gated, e.gc);
      end
    end

    // Async reset mid-GATED takes effect between clock edges.
    #3;
    reset = 1'b1;
    #1;
    chk("midsleep_rst_clk_en", int'(bus_a.clk_en), 1);
    chk("midsleep_rst_pe_ready", int'(bus_a.pe_ready), 1);
    chk("midsleep_rst_gated", int'(bus_a.gated), 0);
    chk("midsleep_rst_gated_cycles", int'(bus_a.gated_cycles), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_idle_clk_en", int'(bus_a.clk_en), 1);

    // Narrow instance: IDLE_CYCLES=1 gates on the first idle edge, stat saturates at 15.
    @(negedge clk);
    bus_b.pe_busy = 1'b0;
    @(posedge clk);
    #1;
    chk("b_gate_clk_en", int'(bus_b.clk_en), 0);
    chk("b_gate_gated", int'(bus_b.gated), 1);
    chk("b_gate_gc", int'(bus_b.gated_cycles), 0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b_sat_gc_%0d", k), int'(bus_b.gated_cycles), (k < 15) ? k : 15);
    end
    // WAKE_CYCLES=0: wake lands straight in ACTIVE with pe_ready.
    @(negedge clk);
    bus_b.wake_req = 1'b1;
    @(posedge clk);
    #1;
    chk("b_wake_clk_en", int'(bus_b.clk_en), 1);
    chk("b_wake_pe_ready", int'(bus_b.pe_ready), 1);
    chk("b_wake_gated", int'(bus_b.gated), 0);
    chk("b_wake_gc", int'(bus_b.gated_cycles), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
